cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Synthesizable run-control block for the pipelined RISC-V CPU.
- Streams a program into instruction memory over a valid/ready port, holds the CPU in reset while it loads, then releases reset for a configurable hold period.
- Counts run cycles and detects halt on retirement of ECALL/EBREAK or on timeout.
- Sits between a host/bench program source and the CPU's imem write port and reset input.

Parameters:
- XLEN, 32, instruction/data word width.
- IMEM_DEPTH, 64, instruction memory depth in words (power of two, ≥2).
- TIMEOUT_CYCLES, 200, RUN cycles before forced halt (≥1).
- RESET_HOLD, 2, cycles cpu_reset stays high after load completes (≥1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins load; sampled only in IDLE/DONE.
- prog_valid  in  1  program word valid.
- prog_ready  out  1  block accepts program word.
- prog_data  in  XLEN  program word.
- prog_last  in  1  marks final program word.
- imem_we  out  1  imem write enable.
- imem_addr  out  $clog2(IMEM_DEPTH)  imem word address.
- imem_wdata  out  XLEN  imem write data.
- cpu_reset  out  1  reset to the CPU (active-high).
- retire_valid  in  1  CPU retired an instruction this cycle.
- retire_instr  in  32  encoding of the retired instruction.
- words_loaded  out  $clog2(IMEM_DEPTH)+1  count of words written.
- cycle_count  out  32  RUN cycles elapsed.
- done  out  1  run finished (sticky until the next start).
- timeout  out  1  finished by timeout.
- halt_code  out  2  halt cause: 00 none, 01 ECALL, 10 EBREAK, 11 timeout.
- retire_count  out  32  retired instruction count (see Optional Feature).

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, DONE.
- Reset, from any state and mid-operation:
  - State goes to IDLE.
  - cpu_reset=1; prog_ready=0; imem_we=0; imem_addr=0; imem_wdata=0.
  - words_loaded=0; cycle_count=0; done=0; timeout=0; halt_code=00; retire_count=0.
- IDLE:
  - cpu_reset=1.
  - On start, go to LOAD and clear the load pointer, words_loaded, cycle_count, done, timeout and halt_code.
- LOAD:
  - prog_ready=1 and cpu_reset=1.
  - A handshake occurs when prog_valid and prog_ready are both high.
  - On each handshake, next cycle (1-cycle registered latency): imem_we=1, imem_addr=pointer, imem_wdata=prog_data. Then the pointer increments and words_loaded increments.
  - imem_we is 0 in every cycle with no handshake.
  - A handshake with prog_last, or the handshake that fills address IMEM_DEPTH-1, moves the FSM to HOLD.
  - prog_ready is low from HOLD onward, so extra words stall and are never written.
  - A load with zero words stays in LOAD indefinitely.
- HOLD:
  - cpu_reset=1 for exactly RESET_HOLD cycles, which also covers the final registered imem write.
  - Then go to RUN.
- RUN:
  - cpu_reset=0; cycle_count increments every cycle.
  - Halt when retire_valid=1 and retire_instr==32'h00000073 (ECALL, halt_code 01) or 32'h00100073 (EBREAK, halt_code 10). The next state is DONE.
  - When cycle_count reaches TIMEOUT_CYCLES, go to DONE with timeout=1 and halt_code=11.
  - Halt and timeout in the same cycle: the halt wins, timeout=0.
  - cycle_count saturates; it never wraps.
- DONE:
  - done=1 and cpu_reset=1; counters are frozen.
  - start re-enters LOAD and clears all status as in IDLE.
  - start in LOAD/HOLD/RUN is ignored.

Optional Feature:
- Macro RUN_TRACE_EN.
- Defined:
  - retire_count increments on each retire_valid in RUN, including the halting instruction.
  - It is cleared on start and reset and saturates at 32'hFFFFFFFF.
  - Each retirement prints $display("retire %0d instr=%h", retire_count, retire_instr) in simulation only (non-synthesizable part guarded).
- Undefined: retire_count is tied to 0 and no counter logic or prints are generated.

Test Plan:
- Load and halt:
  - Stimulus: reset 2 cycles, start, stream 00500093, 00A00113, 002081B3, 00000073 with last on the 4th word.
  - Response: imem writes at addr 0..3 with those words, words_loaded=4, cpu_reset low after RESET_HOLD=2 cycles, retire of 00000073 gives done=1, halt_code=01, timeout=0.
- Timeout:
  - Stimulus: load 1 word, retire_valid never asserted.
  - Response: done=1, timeout=1, halt_code=11, cycle_count=200, cpu_reset=1.
- Backpressure and overflow:
  - Stimulus: IMEM_DEPTH=4, stream 6 words with no last and prog_valid gaps.
  - Response: exactly 4 writes (addr 0..3) occur and prog_ready is low afterwards.
- Simultaneous events:
  - Stimulus: EBREAK 00100073 retires in the cycle cycle_count hits TIMEOUT_CYCLES.
  - Response: halt_code=10, timeout=0.
- Reset mid-operation:
  - Stimulus: assert reset during RUN and again during LOAD.
  - Response: next cycle IDLE, cpu_reset=1, all counters 0; a following start reloads from addr 0.
- Restart from DONE:
  - Stimulus: start after DONE.
  - Response: done clears next cycle, LOAD begins at addr 0; with RUN_TRACE_EN defined, retire_count restarts from 0.

Source files
------------

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: loads a program into the CPU's instruction memory,
// holds the CPU in reset while loading and for RESET_HOLD cycles after,
// then lets it run until ECALL/EBREAK retires or TIMEOUT_CYCLES elapse.
// Optional retirement counter/trace: define RUN_TRACE_EN.
module cpu_run_controller #(
  parameter int XLEN           = 32,
  parameter int IMEM_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int RESET_HOLD     = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_prog_valid,
  output logic                          o_prog_ready,
  input  logic [XLEN-1:0]               i_prog_data,
  input  logic                          i_prog_last,
  output logic                          o_imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] o_imem_addr,
  output logic [XLEN-1:0]               o_imem_wdata,
  output logic                          o_cpu_reset,
  input  logic                          i_retire_valid,
  input  logic [31:0]                   i_retire_instr,
  output logic [$clog2(IMEM_DEPTH):0]   o_words_loaded,
  output logic [31:0]                   o_cycle_count,
  output logic                          o_done,
  output logic                          o_timeout,
  output logic [1:0]                    o_halt_code,
  output logic [31:0]                   o_retire_count
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_ptr;
  logic [AW:0]     r_words_loaded;
  logic            r_imem_we;
  logic [AW-1:0]   r_imem_addr;
  logic [XLEN-1:0] r_imem_wdata;
  logic [31:0]     r_hold_cnt;
  logic [31:0]     r_cycle_count;
  logic            r_timeout;
  logic [1:0]      r_halt_code;

  logic            w_start_acc;
  logic            w_hs;
  logic            w_hs_end;
  logic            w_in_run;
  logic            w_ecall;
  logic            w_ebreak;
  logic [31:0]     w_cc_inc;
  logic            w_to_hit;
  logic            w_hold_end;

  // start only counts when the block is idle or finished
  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hs        = (r_state == S_LOAD) && i_prog_valid;
  // the word written to the last address ends the load even without prog_last
  assign w_hs_end    = w_hs && (i_prog_last || (r_ptr == AW'(IMEM_DEPTH - 1)));
  assign w_in_run    = (r_state == S_RUN);
  assign w_ecall     = w_in_run && i_retire_valid && (i_retire_instr == INSTR_ECALL);
  assign w_ebreak    = w_in_run && i_retire_valid && (i_retire_instr == INSTR_EBREAK);
  // saturating increment: the run counter never wraps
  assign w_cc_inc    = (r_cycle_count == 32'hFFFF_FFFF) ? r_cycle_count : r_cycle_count + 32'd1;
  // timeout fires in the RUN cycle that brings the count to TIMEOUT_CYCLES
  assign w_to_hit    = w_in_run && (w_cc_inc >= 32'(TIMEOUT_CYCLES));
  assign w_hold_end  = (r_hold_cnt == 32'(RESET_HOLD - 1));

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_LOAD;
      S_LOAD: if (w_hs_end) w_state_nxt = S_HOLD;
      S_HOLD: if (w_hold_end) w_state_nxt = S_RUN;
      S_RUN:  if (w_ecall || w_ebreak || w_to_hit) w_state_nxt = S_DONE;
      S_DONE: if (i_start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    o_cpu_reset  = 1'b1;
    o_prog_ready = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_LOAD: o_prog_ready = 1'b1;
      S_RUN:  o_cpu_reset  = 1'b0;
      S_DONE: o_done       = 1'b1;
      default: ;
    endcase
  end

  // registered imem write port: one cycle behind the accepting handshake
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= w_hs;
      if (w_hs) begin
        r_imem_addr  <= r_ptr;
        r_imem_wdata <= i_prog_data;
      end
    end
  end

  // load pointer and loaded-word counter
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc) begin
      r_ptr          <= '0;
      r_words_loaded <= '0;
    end else if (w_hs) begin
      r_ptr          <= r_ptr + AW'(1);
      r_words_loaded <= r_words_loaded + (AW+1)'(1);
    end
  end

  // hold counter: restarts whenever the FSM is outside HOLD
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state != S_HOLD)) r_hold_cnt <= '0;
    else                                r_hold_cnt <= r_hold_cnt + 32'd1;
  end

  // run cycle counter, frozen outside RUN
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc) r_cycle_count <= '0;
    else if (w_in_run)          r_cycle_count <= w_cc_inc;
  end

  // halt cause; a retiring ECALL/EBREAK beats a coincident timeout
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc) begin
      r_timeout   <= 1'b0;
      r_halt_code <= 2'b00;
    end else if (w_ecall) begin
      r_halt_code <= 2'b01;
    end else if (w_ebreak) begin
      r_halt_code <= 2'b10;
    end else if (w_to_hit) begin
      r_timeout   <= 1'b1;
      r_halt_code <= 2'b11;
    end
  end

`ifdef RUN_TRACE_EN
  logic [31:0] r_retire_count;

  // retired instruction counter, saturating, includes the halting instruction
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc)
      r_retire_count <= '0;
    else if (w_in_run && i_retire_valid && (r_retire_count != 32'hFFFF_FFFF))
      r_retire_count <= r_retire_count + 32'd1;
  end

  assign o_retire_count = r_retire_count;

`ifndef SYNTHESIS
  // simulation-only retirement trace
  always @(posedge i_clk) begin
    if (!i_reset && w_in_run && i_retire_valid)
      $display("retire %0d instr=%h", r_retire_count, i_retire_instr);
  end
`endif
`else
  assign o_retire_count = 32'd0;
`endif

  assign o_imem_we      = r_imem_we;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = r_imem_wdata;
  assign o_words_loaded = r_words_loaded;
  assign o_cycle_count  = r_cycle_count;
  assign o_timeout      = r_timeout;
  assign o_halt_code    = r_halt_code;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a default-size instance for load/run/halt
// tests and an IMEM_DEPTH=4 instance for the overflow test. Expected imem
// writes are queued as words are handed over and matched as writes appear.
module tb_cpu_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

`ifdef RUN_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  // main instance signals
  logic        reset, start, p_valid, p_last, retire_valid;
  logic [31:0] p_data, retire_instr;
  logic        p_ready, imem_we, cpu_reset, done, timeout;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata, cycle_count, retire_count;
  logic [6:0]  words_loaded;
  logic [1:0]  halt_code;

  // small instance signals
  logic        s_reset, s_start, s_valid, s_last, s_retire_valid;
  logic [31:0] s_data, s_retire_instr;
  logic        s_ready, s_imem_we, s_cpu_reset, s_done, s_timeout;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata, s_cycle_count, s_retire_count;
  logic [2:0]  s_words_loaded;
  logic [1:0]  s_halt_code;

  cpu_run_controller u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_prog_valid(p_valid), .o_prog_ready(p_ready), .i_prog_data(p_data), .i_prog_last(p_last),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_cpu_reset(cpu_reset), .i_retire_valid(retire_valid), .i_retire_instr(retire_instr),
    .o_words_loaded(words_loaded), .o_cycle_count(cycle_count), .o_done(done),
    .o_timeout(timeout), .o_halt_code(halt_code), .o_retire_count(retire_count)
  );

  cpu_run_controller #(.IMEM_DEPTH(4)) u_dut4 (
    .i_clk(clk), .i_reset(s_reset), .i_start(s_start),
    .i_prog_valid(s_valid), .o_prog_ready(s_ready), .i_prog_data(s_data), .i_prog_last(s_last),
    .o_imem_we(s_imem_we), .o_imem_addr(s_imem_addr), .o_imem_wdata(s_imem_wdata),
    .o_cpu_reset(s_cpu_reset), .i_retire_valid(s_retire_valid), .i_retire_instr(s_retire_instr),
    .o_words_loaded(s_words_loaded), .o_cycle_count(s_cycle_count), .o_done(s_done),
    .o_timeout(s_timeout), .o_halt_code(s_halt_code), .o_retire_count(s_retire_count)
  );

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] sb0_addr, sb1_addr;
  logic [63:0] e0, e1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write monitors: every imem write must match the head of the queue
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (q0.size() == 0) chk("we0_unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("waddr0", 64'(imem_addr), 64'(e0[63:32]));
        chk("wdata0", 64'(imem_wdata), 64'(e0[31:0]));
      end
    end
    if (s_imem_we === 1'b1) begin
      if (q1.size() == 0) chk("we1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("waddr1", 64'(s_imem_addr), 64'(e1[63:32]));
        chk("wdata1", 64'(s_imem_wdata), 64'(e1[31:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
    sb0_addr = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(1); reset = 1'b0;
    sb0_addr = 0;
  endtask

  // hand one word over; the expected write is queued when it is accepted
  task automatic send(input int inst, input logic [31:0] d, input logic last, input int gap);
    int n;
    tick(gap);
    if (inst == 0) begin p_valid = 1'b1; p_data = d; p_last = last; end
    else           begin s_valid = 1'b1; s_data = d; s_last = last; end
    n = 0;
    while (((inst == 0) ? !p_ready : !s_ready) && n < 20) begin tick(1); n++; end
    if (n >= 20) chk("handshake_wait", 0, 1);
    else begin
      if (inst == 0) begin q0.push_back({sb0_addr, d}); sb0_addr++; end
      else           begin q1.push_back({sb1_addr, d}); sb1_addr++; end
      tick(1);
    end
    if (inst == 0) begin p_valid = 1'b0; p_last = 1'b0; end
    else           begin s_valid = 1'b0; s_last = 1'b0; end
  endtask

  task automatic retire(input logic [31:0] instr, input logic vld);
    retire_valid = vld; retire_instr = instr; tick(1);
    retire_valid = 1'b0; retire_instr = 32'h0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_ready"}, p_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_words"}, words_loaded, 0);
    chk({tag, "_cycles"}, cycle_count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_halt"}, halt_code, 0);
    chk({tag, "_retired"}, retire_count, 0);
  endtask

  logic [31:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000073};

  initial begin
    int n;
    reset = 1; start = 0; p_valid = 0; p_last = 0; p_data = 0;
    retire_valid = 0; retire_instr = 0;
    s_reset = 1; s_start = 0; s_valid = 0; s_last = 0; s_data = 0;
    s_retire_valid = 0; s_retire_instr = 0;
    sb0_addr = 0; sb1_addr = 0;

    // reset state
    tick(2); reset = 1'b0;
    chk_cleared("rst");

    // load four words and halt on ECALL
    pulse_start();
    chk("load_ready", p_ready, 1);
    for (int i = 0; i < 4; i++) send(0, prog[i], i == 3, i % 2);
    chk("load_words", words_loaded, 4);
    chk("hold1_cpu_reset", cpu_reset, 1);
    chk("hold_ready", p_ready, 0);
    tick(1);
    chk("hold2_cpu_reset", cpu_reset, 1);
    tick(1);
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_cycles0", cycle_count, 0);
    for (int i = 0; i < 3; i++) retire(prog[i], 1'b1);
    retire(32'h00000073, 1'b0);
    tick(1);
    chk("not_halted", done, 0);
    retire(32'h00000073, 1'b1);
    chk("ecall_done", done, 1);
    chk("ecall_halt", halt_code, 2'b01);
    chk("ecall_timeout", timeout, 0);
    chk("ecall_cycles", cycle_count, 6);
    chk("ecall_cpu_reset", cpu_reset, 1);
    chk("ecall_retired", retire_count, TRACE ? 4 : 0);
    tick(3);
    chk("done_frozen", cycle_count, 6);
    chk("done_sticky", done, 1);

    // restart from DONE, then one-word load that times out
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_ready", p_ready, 1);
    chk("restart_words", words_loaded, 0);
    chk("restart_cycles", cycle_count, 0);
    chk("restart_halt", halt_code, 0);
    chk("restart_retired", retire_count, 0);
    send(0, 32'h0000006F, 1'b1, 0);
    n = 0;
    while (!done && n < 400) begin tick(1); n++; end
    chk("to_latency", n, 202);
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_halt", halt_code, 2'b11);
    chk("to_cycles", cycle_count, 200);
    chk("to_cpu_reset", cpu_reset, 1);

    // EBREAK retiring in the very cycle that would time out
    pulse_start();
    send(0, 32'h00100073, 1'b1, 0);
    tick(2);
    chk("sim_run", cpu_reset, 0);
    tick(199);
    chk("sim_pre_cycles", cycle_count, 199);
    chk("sim_pre_done", done, 0);
    retire(32'h00100073, 1'b1);
    chk("sim_done", done, 1);
    chk("sim_halt", halt_code, 2'b10);
    chk("sim_timeout", timeout, 0);
    chk("sim_cycles", cycle_count, 200);
    chk("sim_retired", retire_count, TRACE ? 1 : 0);

    // reset during RUN
    pulse_start();
    send(0, prog[0], 1'b0, 0);
    send(0, prog[1], 1'b1, 0);
    tick(2);
    retire(prog[0], 1'b1);
    tick(9);
    chk("mid_run_cycles", cycle_count, 10);
    pulse_reset();
    chk_cleared("rst_run");

    // reset during LOAD, then reload from address 0
    pulse_start();
    send(0, 32'hDEADBEEF, 1'b0, 0);
    chk("mid_load_words", words_loaded, 1);
    pulse_reset();
    chk("rst_load_words", words_loaded, 0);
    chk("rst_load_ready", p_ready, 0);
    chk("rst_load_we", imem_we, 0);
    pulse_start();
    send(0, prog[2], 1'b0, 1);
    send(0, prog[3], 1'b1, 0);
    chk("reload_words", words_loaded, 2);
    tick(2);
    retire(32'h00000073, 1'b1);
    chk("reload_halt", halt_code, 2'b01);

    // overflow on the four-word instance: six words, no last, gaps
    tick(1); s_reset = 1'b0;
    s_start = 1'b1; tick(1); s_start = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 32'hA000_0000 + 32'(i), 1'b0, (i == 2) ? 2 : 1);
    chk("ovf_ready", s_ready, 0);
    chk("ovf_words", s_words_loaded, 4);
    for (int w = 4; w < 6; w++) begin
      s_valid = 1'b1; s_data = 32'hA000_0000 + 32'(w);
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("ovf_stall_ready", s_ready, 0);
      end
      s_valid = 1'b0; tick(1);
    end
    chk("ovf_words_final", s_words_loaded, 4);
    chk("ovf_we", s_imem_we, 0);

    tick(2);
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
